// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer countdown controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package egg_timer_pkg;

  localparam int TIME_W = 6;
  localparam logic [TIME_W-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    ALARM   = 2'd3
  } state_t;

  // True when an MM:SS pair reads 00:00.
  function automatic logic is_zero(input logic [TIME_W-1:0] m, input logic [TIME_W-1:0] s);
    return (m == '0) && (s == '0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-style divider: one-cycle tick every DIV cycles while run is high.
// Latency: tick is combinational from the held count (count == DIV-1).
// Backpressure: none; run=0 freezes the count, clr=1 zeroes it.
module tick_prescaler #(
  parameter int DIV = 100000000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == CNT_W'(DIV - 1));

  // Count while enabled, wrap on the tick cycle, clear has priority over run.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown controller: MM:SS setting, 1 Hz countdown, pause and alarm.
// Latency: a button pulse in cycle N shows on the registered outputs after that edge.
// Backpressure: none; single-cycle button pulses are always consumed.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int MAX_MIN    = 59,
  parameter int ALARM_SECS = 10
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              btn_start,
  input  logic              btn_clear,
  input  logic              btn_min_up,
  input  logic              btn_sec_up,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] seconds,
  output logic              running,
  output logic              alarm,
  output logic [1:0]        state
);

  localparam int ACNT_W = $clog2(ALARM_SECS + 1);

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   min_d, sec_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;
  logic                running_d, alarm_d;
  logic                tick, pre_run, pre_clr;
  logic                last_sec;

  // Prescaler runs during countdown and alarm; held at zero in IDLE so every
  // start from IDLE begins a fresh full second.
  assign pre_run = (state_q == RUNNING) || (state_q == ALARM);
  assign pre_clr = btn_clear || (state_q == IDLE);

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk_in (clk_in),
    .reset  (reset),
    .run    (pre_run),
    .clr    (pre_clr),
    .tick   (tick)
  );

  // The next decrement lands on 00:00 only when counting down from 00:01.
  assign last_sec = (minutes == '0) && (seconds == TIME_W'(1));
  assign state    = state_q;

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clear beats start, and a final tick beats a pause request.
  always_comb begin
    state_d = state_q;
    if (btn_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (btn_start && !is_zero(minutes, seconds)) state_d = RUNNING;
        RUNNING: begin
          if (tick && last_sec)  state_d = ALARM;
          else if (btn_start)    state_d = PAUSED;
        end
        PAUSED:  if (btn_start) state_d = RUNNING;
        ALARM: begin
          if (btn_start)                                           state_d = IDLE;
          else if (tick && (acnt_q == ACNT_W'(ALARM_SECS - 1)))    state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath logic: time fields, alarm counter and status flags.
  always_comb begin
    min_d     = minutes;
    sec_d     = seconds;
    acnt_d    = acnt_q;
    running_d = (state_d == RUNNING);
    alarm_d   = (state_d == ALARM);
    if (btn_clear) begin
      min_d  = '0;
      sec_d  = '0;
      acnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Setting buttons yield to a start press in the same cycle.
          if (!btn_start) begin
            if (btn_min_up) min_d = (minutes >= TIME_W'(MAX_MIN)) ? '0 : minutes + TIME_W'(1);
            if (btn_sec_up) sec_d = (seconds >= SEC_MAX) ? '0 : seconds + TIME_W'(1);
          end
        end
        RUNNING: begin
          if (tick && !is_zero(minutes, seconds)) begin
            if (seconds != '0) begin
              sec_d = seconds - TIME_W'(1);
            end else begin
              min_d = minutes - TIME_W'(1);
              sec_d = SEC_MAX;
            end
          end
        end
        ALARM: begin
          min_d = '0;
          sec_d = '0;
          if (btn_start)
            acnt_d = '0;
          else if (tick)
            acnt_d = (acnt_q == ACNT_W'(ALARM_SECS - 1)) ? '0 : acnt_q + ACNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs and alarm counter.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      minutes <= '0;
      seconds <= '0;
      acnt_q  <= '0;
      running <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      minutes <= min_d;
      seconds <= sec_d;
      acnt_q  <= acnt_d;
      running <= running_d;
      alarm   <= alarm_d;
    end
  end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with a 4-cycle second and a 2-second alarm.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_egg_timer_ctrl;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       btn_start, btn_clear, btn_min_up, btn_sec_up;
  logic [5:0] minutes, seconds;
  logic       running, alarm;
  logic [1:0] state;
  logic [15:0] obs;

  int pass_n = 0;
  int chk_n  = 0;

  egg_timer_ctrl #(.TICK_DIV(4), .MAX_MIN(59), .ALARM_SECS(2)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_min_up (btn_min_up),
    .btn_sec_up (btn_sec_up),
    .minutes    (minutes),
    .seconds    (seconds),
    .running    (running),
    .alarm      (alarm),
    .state      (state)
  );

  always #5 clk_in = ~clk_in;

  // Packed view: {state, running, alarm, minutes, seconds}.
  assign obs = {state, running, alarm, minutes, seconds};

  function automatic logic [15:0] exp_v(input logic [1:0] st, input int m, input int s);
    logic [5:0] mm, ss;
    mm = m[5:0];
    ss = s[5:0];
    return {st, st == 2'd1, st == 2'd3, mm, ss};
  endfunction

  // Apply buttons for one cycle; returns just after the edge that consumed them.
  task automatic step(input logic s, input logic c, input logic mu, input logic su);
    btn_start = s; btn_clear = c; btn_min_up = mu; btn_sec_up = su;
    @(posedge clk_in); #1;
    btn_start = 0; btn_clear = 0; btn_min_up = 0; btn_sec_up = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_start = 0; btn_clear = 0; btn_min_up = 0; btn_sec_up = 0;
    repeat (2) @(posedge clk_in);
    #1;
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL reset_state: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
    reset = 1'b0;
  endtask

  task automatic test_countdown_alarm();
    step(0,0,0,1); step(0,0,0,1);
    chk_n++; if (obs !== exp_v(0,0,2)) $display("FAIL set_0002: got %h expected %h", obs, exp_v(0,0,2)); else pass_n++;
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(1,0,2)) $display("FAIL start_run: got %h expected %h", obs, exp_v(1,0,2)); else pass_n++;
    wait_cycles(3);
    chk_n++; if (obs !== exp_v(1,0,2)) $display("FAIL before_tick1: got %h expected %h", obs, exp_v(1,0,2)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(1,0,1)) $display("FAIL tick1: got %h expected %h", obs, exp_v(1,0,1)); else pass_n++;
    wait_cycles(3);
    chk_n++; if (obs !== exp_v(1,0,1)) $display("FAIL before_tick2: got %h expected %h", obs, exp_v(1,0,1)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(3,0,0)) $display("FAIL alarm_entry: got %h expected %h", obs, exp_v(3,0,0)); else pass_n++;
    wait_cycles(7);
    chk_n++; if (obs !== exp_v(3,0,0)) $display("FAIL alarm_hold: got %h expected %h", obs, exp_v(3,0,0)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL alarm_expire: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
  endtask

  task automatic test_minute_borrow();
    step(0,0,1,0);
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(1,1,0)) $display("FAIL run_0100: got %h expected %h", obs, exp_v(1,1,0)); else pass_n++;
    wait_cycles(3);
    chk_n++; if (obs !== exp_v(1,1,0)) $display("FAIL borrow_early: got %h expected %h", obs, exp_v(1,1,0)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(1,0,59)) $display("FAIL borrow: got %h expected %h", obs, exp_v(1,0,59)); else pass_n++;
    wait_cycles(3);
    chk_n++; if (obs !== exp_v(1,0,59)) $display("FAIL period_early: got %h expected %h", obs, exp_v(1,0,59)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(1,0,58)) $display("FAIL period_4: got %h expected %h", obs, exp_v(1,0,58)); else pass_n++;
    step(0,1,0,0);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL clear_running: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
  endtask

  task automatic test_pause_resume();
    repeat (5) step(0,0,0,1);
    step(1,0,0,0);
    wait_cycles(1);
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(2,0,5)) $display("FAIL pause_enter: got %h expected %h", obs, exp_v(2,0,5)); else pass_n++;
    wait_cycles(20);
    chk_n++; if (obs !== exp_v(2,0,5)) $display("FAIL pause_hold: got %h expected %h", obs, exp_v(2,0,5)); else pass_n++;
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(1,0,5)) $display("FAIL resume: got %h expected %h", obs, exp_v(1,0,5)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(1,0,5)) $display("FAIL resume_early: got %h expected %h", obs, exp_v(1,0,5)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(1,0,4)) $display("FAIL resume_tick: got %h expected %h", obs, exp_v(1,0,4)); else pass_n++;
    wait_cycles(3);
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(2,0,3)) $display("FAIL pause_with_tick: got %h expected %h", obs, exp_v(2,0,3)); else pass_n++;
    step(0,1,0,0);
    step(0,0,0,1);
    step(1,0,0,0);
    wait_cycles(3);
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(3,0,0)) $display("FAIL alarm_beats_pause: got %h expected %h", obs, exp_v(3,0,0)); else pass_n++;
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL start_ends_alarm: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
  endtask

  task automatic test_wraps();
    repeat (59) step(0,0,1,0);
    chk_n++; if (obs !== exp_v(0,59,0)) $display("FAIL min_59: got %h expected %h", obs, exp_v(0,59,0)); else pass_n++;
    step(0,0,1,0);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL min_wrap: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
    repeat (59) step(0,0,0,1);
    chk_n++; if (obs !== exp_v(0,0,59)) $display("FAIL sec_59: got %h expected %h", obs, exp_v(0,0,59)); else pass_n++;
    step(0,0,1,1);
    chk_n++; if (obs !== exp_v(0,1,0)) $display("FAIL both_up_no_carry: got %h expected %h", obs, exp_v(0,1,0)); else pass_n++;
    step(0,1,0,0);
  endtask

  task automatic test_start_zero_and_clear();
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL start_at_zero: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
    step(0,0,0,1);
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(1,0,1)) $display("FAIL run_0001: got %h expected %h", obs, exp_v(1,0,1)); else pass_n++;
    step(1,1,0,0);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL clear_beats_start: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
  endtask

  task automatic test_reset_mid_run();
    repeat (3) step(0,0,1,0);
    repeat (17) step(0,0,0,1);
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(1,3,17)) $display("FAIL run_0317: got %h expected %h", obs, exp_v(1,3,17)); else pass_n++;
    wait_cycles(2);
    reset = 1'b1;
    @(posedge clk_in); #1;
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL reset_mid_run: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
    reset = 1'b0;
    step(1,0,0,0);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL start_after_reset: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
    step(0,0,0,1);
    step(1,0,0,0);
    wait_cycles(3);
    chk_n++; if (obs !== exp_v(1,0,1)) $display("FAIL no_residual_count: got %h expected %h", obs, exp_v(1,0,1)); else pass_n++;
    wait_cycles(1);
    chk_n++; if (obs !== exp_v(3,0,0)) $display("FAIL fresh_tick_alarm: got %h expected %h", obs, exp_v(3,0,0)); else pass_n++;
    step(0,1,0,0);
    chk_n++; if (obs !== exp_v(0,0,0)) $display("FAIL clear_alarm: got %h expected %h", obs, exp_v(0,0,0)); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_countdown_alarm();
    test_minute_borrow();
    test_pause_resume();
    test_wraps();
    test_start_zero_and_clear();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/egg_timer_ctrl.md
Name: egg_timer_ctrl

Overview:
- Countdown controller for the egg timer. It sequences the 1 Hz time base and owns the MM:SS countdown state and the alarm.
- The divider is an enable-style prescaler held inside the block: it emits a single-cycle tick and never drives a derived clock. The controller starts, pauses and clears this prescaler.
- Sits between the debounced button front end and the display driver. Outputs are registered MM:SS values plus status flags.

Parameters:
- TICK_DIV, 100000000, clk_in cycles per one-second tick; must be >= 2.
- MAX_MIN, 59, highest settable minute value; the minute field wraps to 0 above this.
- ALARM_SECS, 10, number of ticks the alarm stays asserted before auto-return to IDLE; must be >= 1.

Ports:
- clk_in, input, 1, single system clock; all state changes on its rising edge.
- reset, input, 1, synchronous, active-high; sampled on the clk_in rising edge.
- btn_start, input, 1, one-cycle pulse, start/pause toggle.
- btn_clear, input, 1, one-cycle pulse, abort and zero the time.
- btn_min_up, input, 1, one-cycle pulse, increment minutes (IDLE only).
- btn_sec_up, input, 1, one-cycle pulse, increment seconds (IDLE only).
- minutes, output, 6, current minutes, 0..MAX_MIN.
- seconds, output, 6, current seconds, 0..59.
- running, output, 1, high while state is RUNNING.
- alarm, output, 1, high while state is ALARM.
- state, output, 2, encoding: IDLE=0, RUNNING=1, PAUSED=2, ALARM=3.

Behaviour:
- Reset (synchronous, active-high, priority over everything): state=IDLE, minutes=0, seconds=0, running=0, alarm=0, prescaler=0, alarm counter=0.
- All outputs are registered. A button pulse in cycle N is visible on the outputs after the edge that ends cycle N (1-cycle latency).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING and ALARM.
  - tick=1 in the cycle where count==TICK_DIV-1; count wraps to 0 on that edge.
  - Held (frozen) in PAUSED.
  - Forced to 0 in IDLE and on every entry to RUNNING from IDLE.
  - Result: the first decrement occurs exactly TICK_DIV cycles after start.
- Input priority per cycle: reset > btn_clear > btn_start > tick > up buttons.
- btn_clear in any state: next state IDLE, time 00:00, prescaler 0, alarm 0.
- IDLE:
  - btn_min_up: minutes+1, MAX_MIN wraps to 0.
  - btn_sec_up: seconds+1, 59 wraps to 0; no carry into minutes.
  - Both up buttons in the same cycle: both fields apply.
  - btn_start with time != 00:00: go to RUNNING. With 00:00: ignored, stay IDLE.
- RUNNING:
  - On tick: if seconds>0, seconds-1. Else minutes-1 and seconds=59.
  - If the decrement produces 00:00, go to ALARM on the same edge.
  - btn_start: go to PAUSED. A tick in the same cycle is still applied.
  - If that same-cycle tick reaches 00:00, ALARM wins over PAUSED.
  - Up buttons are ignored.
- PAUSED:
  - Time and prescaler frozen.
  - btn_start: go to RUNNING, resuming the prescaler from its held count.
  - Up buttons are ignored.
- ALARM:
  - alarm=1; time held at 00:00.
  - Alarm counter increments on each tick. When it reaches ALARM_SECS, go to IDLE and clear the alarm counter.
  - btn_start or btn_clear: go to IDLE immediately.
- Reset mid-countdown: behaves exactly as power-on reset; no residual prescaler count.
- Arithmetic: 6-bit unsigned fields. Decrement is never applied at 00:00. The prescaler is sized as $clog2(TICK_DIV).

Decomposition:
- Package egg_timer_pkg:
  - state encoding constants IDLE/RUNNING/PAUSED/ALARM;
  - SEC_MAX=59;
  - field width constant TIME_W=6.
- Sub-module tick_prescaler, parameter DIV. Ports clk_in, reset, run, clr, tick.
  - run=0 holds the count; clr=1 zeroes it.
  - Enable-pulse output only; it replaces toggled-clock division in the new design.

Test Plan (TICK_DIV=4, ALARM_SECS=2, MAX_MIN=59):
- Reset, then 2x btn_sec_up, then btn_start -> state=1. Seconds 2→1 at +4 cycles, 1→0 at +8 cycles with state=3 and alarm=1. Alarm clears and state=0 at 8 cycles later.
- Set 01:00, start -> after 4 cycles minutes=0, seconds=59. Verify tick period is exactly 4 cycles.
- Running at 00:05: btn_start after 2 cycles -> PAUSED, time held for 20 cycles. btn_start again -> next decrement 2 cycles later (prescaler resumed).
- IDLE: 60x btn_min_up -> minutes wraps to 0. Simultaneous btn_min_up+btn_sec_up at 00:59 -> 01:00? No: must give minutes=1, seconds=0 (independent wraps, no carry).
- btn_start at 00:00 in IDLE -> state stays 0. btn_clear together with btn_start while RUNNING -> IDLE, 00:00.
- Synchronous reset asserted mid-RUNNING at 03:17 -> next edge all outputs 0, state=0. After release, start is ignored until time is set.
